// File: rtl/prf_release_int_pkg.sv
// Shared micro-op values for the integer PRF release path: lane widths,
// physical register file geometry and the release-entry type.
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif

package prf_release_int_pkg;

    localparam int unsigned PRF_INT_SIZE       = 64;
    localparam int unsigned PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);

    // One queued stale physical register index.
    typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_int_idx_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/prf_release_int_release_queue.sv
// Circular FIFO of stale physical registers: up to PUSH_W writes and up to
// POP_W reads per cycle. Pointers carry an extra wrap bit so that full and
// empty are told apart. Pops are unconditional: the consumer always accepts.
module release_queue
    import prf_release_int_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PUSH_W = 4,
    parameter int unsigned POP_W  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic [$clog2(PUSH_W+1)-1:0]       push_cnt_i,
    input  prf_int_idx_t [PUSH_W-1:0]         push_data_i,
    output logic [POP_W-1:0]                  pop_valid_o,
    output prf_int_idx_t [POP_W-1:0]          pop_data_o,
    output logic [$clog2(DEPTH):0]            count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] pop_cnt;
    prf_int_idx_t     mem_q [DEPTH];

    assign count   = tail_q - head_q;
    assign count_o = count;

    // Present the head entries and advance pointers by pushed/popped amounts.
    always_comb begin
        pop_cnt     = PTR_W'(min_u(32'(count), POP_W));
        pop_valid_o = '0;
        pop_data_o  = '0;
        for (int unsigned i = 0; i < POP_W; i++) begin
            pop_valid_o[i] = PTR_W'(i) < pop_cnt;
            if (pop_valid_o[i]) begin
                pop_data_o[i] = mem_q[IDX_W'(head_q + PTR_W'(i))];
            end
        end
        head_d = head_q + pop_cnt;
        tail_d = tail_q + PTR_W'(push_cnt_i);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    // Pointer registers; reset dominates flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Write compacted pushes into consecutive slots starting at the tail.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < PUSH_W; i++) begin
            if (PTR_W'(i) < PTR_W'(push_cnt_i)) begin
                mem_q[IDX_W'(tail_q + PTR_W'(i))] <= push_data_i[i];
            end
        end
    end

endmodule

// File: rtl/prf_release_int.sv
// Commit-side release of integer physical registers: queues stale mappings
// for the speculative free list and keeps the architectural free list used
// for recovery. Optional macro PRF_RELEASE_CHECK_EN adds a sticky
// double_free_err output.
module prf_release_int
    import prf_release_int_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH  = 16,
    parameter int unsigned COMMIT_WIDTH = `COMMIT_WIDTH,
    parameter int unsigned RENAME_WIDTH = `RENAME_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid,
    input  prf_int_idx_t [COMMIT_WIDTH-1:0]   commit_prd_new,
    input  prf_int_idx_t [COMMIT_WIDTH-1:0]   commit_prd_old,
    output logic                              commit_ready,
    input  logic                              flush,
    output logic [RENAME_WIDTH-1:0]           prf_replace_valid,
    output prf_int_idx_t [RENAME_WIDTH-1:0]   prf_replace,
    output logic [PRF_INT_SIZE-1:0]           recover_fl,
    output logic [$clog2(QUEUE_DEPTH):0]      pending_count
`ifdef PRF_RELEASE_CHECK_EN
    ,
    output logic                              double_free_err
`endif
);

    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);

    logic [PRF_INT_SIZE-1:0]         arch_fl_q, arch_fl_d;
    logic [CNT_W-1:0]                enq_cnt;
    prf_int_idx_t [COMMIT_WIDTH-1:0] enq_data;
`ifdef PRF_RELEASE_CHECK_EN
    logic                            err_q;
    logic                            err_set;
`endif

    // Apply commits lane by lane so a higher lane wins a same-cycle conflict.
    always_comb begin
        arch_fl_d = arch_fl_q;
`ifdef PRF_RELEASE_CHECK_EN
        err_set = 1'b0;
`endif
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i]) begin
                if (commit_prd_new[i] != '0) begin
`ifdef PRF_RELEASE_CHECK_EN
                    if (arch_fl_d[commit_prd_new[i]]) err_set = 1'b1;
`endif
                    arch_fl_d[commit_prd_new[i]] = 1'b1;
                end
                if (commit_prd_old[i] != '0) begin
`ifdef PRF_RELEASE_CHECK_EN
                    if (!arch_fl_d[commit_prd_old[i]]) err_set = 1'b1;
`endif
                    arch_fl_d[commit_prd_old[i]] = 1'b0;
                end
            end
        end
    end

    // Compact freeable stale mappings in lane order; slot j takes the j-th
    // qualifying lane so that all array indices stay loop constants.
    always_comb begin
        int unsigned k;
        k        = 0;
        enq_data = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i] && (commit_prd_old[i] != '0)) begin
                for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
                    if (j == k) enq_data[j] = commit_prd_old[i];
                end
                k = k + 1;
            end
        end
        enq_cnt = CNT_W'(k);
    end

    // Architectural free list register; index 0 stays busy from reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            arch_fl_q <= PRF_INT_SIZE'(1);
        end else begin
            arch_fl_q <= arch_fl_d;
        end
    end

`ifdef PRF_RELEASE_CHECK_EN
    // Sticky double-free/double-allocate flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign double_free_err = err_q;
`endif

    release_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .PUSH_W (COMMIT_WIDTH),
        .POP_W  (RENAME_WIDTH)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush),
        .push_cnt_i  (enq_cnt),
        .push_data_i (enq_data),
        .pop_valid_o (prf_replace_valid),
        .pop_data_o  (prf_replace),
        .count_o     (pending_count)
    );

    assign recover_fl   = arch_fl_d;
    assign commit_ready = (QUEUE_DEPTH - 32'(pending_count)) >= COMMIT_WIDTH;

    // A commit group must never arrive without room for all its lanes.
    assert property (@(posedge clock) disable iff (reset)
                     (|commit_valid) |-> commit_ready);

endmodule

// File: doc/prf_release_int.md
# prf_release_int

Commit-side partner of the integer free list: collects stale physical registers from retiring instructions, streams them back to the speculative free list on its `prf_replace_valid`/`prf_replace` port, and maintains the architectural (committed) free list driven onto the free list's `recover_fl` input. Sits between ROB commit and rename.

## Interface
- `QUEUE_DEPTH`, 16, release queue entries; power of two, ≥ 2×`COMMIT_WIDTH`.
- `COMMIT_WIDTH`, `` `COMMIT_WIDTH ``, commit lanes per cycle.
- `RENAME_WIDTH`, `` `RENAME_WIDTH ``, release lanes per cycle.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `commit_valid` in `COMMIT_WIDTH`: lane retires a register-writing uop.
- `commit_prd_new` in `COMMIT_WIDTH`×`PRF_INT_INDEX_SIZE`: new mapping, becomes architectural.
- `commit_prd_old` in `COMMIT_WIDTH`×`PRF_INT_INDEX_SIZE`: stale mapping, to be freed.
- `commit_ready` out 1: queue can accept a full commit group.
- `flush` in 1: same-cycle copy of the free list's `recover`.
- `prf_replace_valid` out `RENAME_WIDTH`: released lanes, packed from lane 0.
- `prf_replace` out `RENAME_WIDTH`×`PRF_INT_INDEX_SIZE`: released indices.
- `recover_fl` out `PRF_INT_SIZE`: architectural free list; 0 = free, 1 = busy.
- `pending_count` out `$clog2(QUEUE_DEPTH)+1`: queue occupancy.

## Operation
- Architectural list `arch_fl`: for each valid lane, set bit `commit_prd_new` to busy and clear bit `commit_prd_old` to free. Index 0 is never freed and never re-marked. Lanes are applied in ascending order, so on a same-cycle conflict the higher lane wins.
- Enqueue: valid lanes with `commit_prd_old != 0` are compacted in lane order and written to consecutive slots at the tail.
- Dequeue: each cycle, `min(pending_count, RENAME_WIDTH)` head entries drive `prf_replace[0..k-1]` with `prf_replace_valid[k-1:0]` set. The head advances by k unconditionally because the free list always accepts.
- `commit_ready = (QUEUE_DEPTH - pending_count) >= COMMIT_WIDTH`. It is computed from registered count only and does not depend on `commit_valid`. Committing while `commit_ready=0` is illegal and is covered by an assertion.
- Pointers are `$clog2(QUEUE_DEPTH)+1` bits, with the MSB used as the wrap bit. Full and empty are distinguished by the wrap bit.
- `recover_fl` is combinational `arch_fl_next`, which includes the current cycle's commits.
- `flush`:
  - The queue is emptied at the clock edge.
  - Entries dequeued in that cycle are driven but ignored by the free list.
  - No register is lost, because every queued register is already free in `recover_fl`.
  - `arch_fl` still applies the current cycle's commits.
- `reset`:
  - `arch_fl = PRF_INT_SIZE'b1`, matching the free list's reset value.
  - Queue is empty and `pending_count = 0`.
  - Reset overrides `flush` and commits.

## Timing
- Reset values:
  - `prf_replace_valid = 0`, `prf_replace = 0`, `pending_count = 0`.
  - `commit_ready = 1`.
  - `recover_fl = PRF_INT_SIZE'b1`, or that value updated by the same-cycle commits.
- Commit-to-release latency is 1 cycle minimum: an entry enqueued at edge t appears on `prf_replace` during cycle t+1.
- `prf_replace*` are driven from registered queue state only and have no combinational path from `commit_*`.
- Simultaneous enqueue and dequeue is legal at any occupancy. Occupancy update: `count_next = count + enq - deq`.
- Full queue: `commit_ready` is 0 until at least `COMMIT_WIDTH` slots free, and drain continues.
- Empty queue: `prf_replace_valid = 0`.

## Configuration
- `PRF_RELEASE_CHECK_EN` defined:
  - Adds output `double_free_err` (1 bit, sticky until reset).
  - The output sets when a committed `commit_prd_old` is already free in `arch_fl`, or when a committed `commit_prd_new` is already busy.
- Not defined: the port and the check logic are absent, with identical functional behaviour otherwise.

## Structure
- `COMMIT_WIDTH`, `RENAME_WIDTH`, `PRF_INT_SIZE` and `PRF_INT_INDEX_SIZE` come from the shared micro-op header.
- A release-entry typedef (`prf_int_idx_t`) is added alongside them.
- Sub-module `release_queue`: a circular FIFO with multi-push (`COMMIT_WIDTH`) and multi-pop (`RENAME_WIDTH`), exposing count.
- Compaction and `arch_fl` update stay in the top module.

## Test plan
Configuration for all scenarios: CW=RW=4, depth 16, PRF 64.
- Reset, then idle: `recover_fl == 64'h1`, `commit_ready = 1`, `prf_replace_valid = 0`.
- Commit lanes 0 and 2 valid (new=5/7, old=3/9): next cycle `prf_replace_valid = 4'b0011`, `prf_replace = {9,3}`; `recover_fl` bits 5 and 7 set, bits 3 and 9 clear.
- Commit with old=0 (x0 destination): nothing enqueued; bit 0 stays busy.
- Commit 4 valid lanes per cycle for 4 cycles: `pending_count` holds at 4. Pre-load 13 entries with drain idle: `commit_ready = 0`.
- `flush` with 6 entries pending and 2 same-cycle commits: queue empty next cycle; `recover_fl` reflects both commits.
- Repeatedly free the same register without re-allocating it (commit old=12, then another commit old=12), with `PRF_RELEASE_CHECK_EN` defined: `double_free_err` rises one cycle later and stays 1 until reset.
